// File: rtl/debug_clk_sequencer_if.sv
// Command channel from the debug host to the clock sequencer.
// Valid/ready handshake carrying a 2-bit opcode and a 32-bit argument.
interface debug_clk_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/debug_clk_sequencer.sv
// Command-driven controller for the debug clock divider: programs ratio/mode/enable,
// issues counted single-step bursts and reports done/busy/error to the host.
module debug_clk_sequencer #(
    parameter int COUNTER_BITS  = 32,
    parameter int PULSE_BITS    = 32,
    parameter int RESET_DIVIDER = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    debug_clk_sequencer_if.slave    cmd,
    input  logic                    abort,
    output logic [COUNTER_BITS-1:0] div_divider,
    output logic                    div_option,
    output logic                    div_out_enable,
    output logic                    div_write_pulse,
    output logic [PULSE_BITS-1:0]   div_pulse,
    output logic                    div_reset,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              mode
);
    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_RESYNC, ST_STEP_WAIT, ST_DONE
    } state_t;

    localparam logic [1:0] OP_SET_DIV = 2'd0;
    localparam logic [1:0] OP_RUN     = 2'd1;
    localparam logic [1:0] OP_STOP    = 2'd2;
    localparam logic [1:0] OP_STEP    = 2'd3;

    localparam logic [1:0] MODE_STOPPED  = 2'd0;
    localparam logic [1:0] MODE_RUNNING  = 2'd1;
    localparam logic [1:0] MODE_STEPPING = 2'd2;

    state_t                  state_q, state_d;
    logic [COUNTER_BITS-1:0] div_divider_q, div_divider_d;
    logic                    div_option_q, div_option_d;
    logic                    div_out_enable_q, div_out_enable_d;
    logic                    div_write_pulse_q, div_write_pulse_d;
    logic [PULSE_BITS-1:0]   div_pulse_q, div_pulse_d;
    logic                    div_reset_q, div_reset_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [1:0]              mode_q, mode_d;
    logic [PULSE_BITS-1:0]   wait_cnt_q, wait_cnt_d;

    logic                    accept;
    logic [COUNTER_BITS-1:0] div_arg;
    logic [PULSE_BITS-1:0]   step_arg;
    logic                    div_arg_bad;

    assign accept      = cmd.cmd_valid && (state_q == ST_IDLE);
    assign div_arg     = cmd.cmd_arg[COUNTER_BITS-1:0];
    assign step_arg    = cmd.cmd_arg[PULSE_BITS-1:0];
    assign div_arg_bad = div_arg < COUNTER_BITS'(2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_SET_DIV: state_d = (!div_arg_bad && mode_q == MODE_RUNNING)
                                              ? ST_RESYNC : ST_DONE;
                        OP_STEP:    state_d = (step_arg != '0) ? ST_STEP_WAIT : ST_DONE;
                        default:    state_d = ST_DONE;
                    endcase
                end
            end
            ST_RESYNC:    state_d = ST_DONE;
            ST_STEP_WAIT: if (abort || wait_cnt_q == '0) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_INIT;
        endcase
    end

    // Next values of every registered output; strobes default low.
    always_comb begin
        div_divider_d     = div_divider_q;
        div_option_d      = div_option_q;
        div_out_enable_d  = div_out_enable_q;
        div_write_pulse_d = 1'b0;
        div_pulse_d       = div_pulse_q;
        div_reset_d       = 1'b0;
        error_d           = error_q;
        mode_d            = mode_q;
        wait_cnt_d        = wait_cnt_q;
        cmd_ready_d       = (state_d == ST_IDLE);
        busy_d            = (state_d != ST_IDLE);
        done_d            = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    error_d = 1'b0;
                    case (cmd.cmd_op)
                        OP_SET_DIV: begin
                            if (div_arg_bad) begin
                                error_d = 1'b1;
                            end else begin
                                div_divider_d = div_arg;
                                // restart divider phase so the new ratio starts clean
                                div_reset_d   = (mode_q == MODE_RUNNING);
                            end
                        end
                        OP_RUN: begin
                            div_option_d     = 1'b1;
                            div_out_enable_d = 1'b1;
                            mode_d           = MODE_RUNNING;
                        end
                        OP_STOP: begin
                            div_option_d     = 1'b0;
                            div_out_enable_d = 1'b0;
                            mode_d           = MODE_STOPPED;
                        end
                        OP_STEP: begin
                            if (step_arg != '0) begin
                                div_option_d      = 1'b0;
                                div_out_enable_d  = 1'b1;
                                div_pulse_d       = step_arg;
                                div_write_pulse_d = 1'b1;
                                wait_cnt_d        = step_arg;
                                mode_d            = MODE_STEPPING;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_STEP_WAIT: begin
                if (abort) begin
                    div_reset_d      = 1'b1;
                    div_out_enable_d = 1'b0;
                    error_d          = 1'b1;
                    mode_d           = MODE_STOPPED;
                end else if (wait_cnt_q == '0) begin
                    // divider output is already idle here, so the enable stays on
                    mode_d = MODE_STOPPED;
                end else begin
                    wait_cnt_d = wait_cnt_q - PULSE_BITS'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_divider_q     <= COUNTER_BITS'(RESET_DIVIDER);
            div_option_q      <= 1'b0;
            div_out_enable_q  <= 1'b0;
            div_write_pulse_q <= 1'b0;
            div_pulse_q       <= '0;
            div_reset_q       <= 1'b1;
            cmd_ready_q       <= 1'b0;
            busy_q            <= 1'b1;
            done_q            <= 1'b0;
            error_q           <= 1'b0;
            mode_q            <= MODE_STOPPED;
            wait_cnt_q        <= '0;
        end else begin
            div_divider_q     <= div_divider_d;
            div_option_q      <= div_option_d;
            div_out_enable_q  <= div_out_enable_d;
            div_write_pulse_q <= div_write_pulse_d;
            div_pulse_q       <= div_pulse_d;
            div_reset_q       <= div_reset_d;
            cmd_ready_q       <= cmd_ready_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            error_q           <= error_d;
            mode_q            <= mode_d;
            wait_cnt_q        <= wait_cnt_d;
        end
    end

    assign cmd.cmd_ready     = cmd_ready_q;
    assign div_divider       = div_divider_q;
    assign div_option        = div_option_q;
    assign div_out_enable    = div_out_enable_q;
    assign div_write_pulse   = div_write_pulse_q;
    assign div_pulse         = div_pulse_q;
    assign div_reset         = div_reset_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign mode              = mode_q;
endmodule

// File: tb/tb_debug_clk_sequencer.sv
// Directed bench for debug_clk_sequencer: command table plus abort and
// mid-burst reset sequences, with a small divider pulse-count model.
module tb_debug_clk_sequencer;
    localparam logic [1:0] OP_SET = 2'd0, OP_RUN = 2'd1, OP_STOP = 2'd2, OP_STEP = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic [31:0] div_divider;
    logic        div_option, div_out_enable, div_write_pulse, div_reset;
    logic [31:0] div_pulse;
    logic        busy, done, error;
    logic [1:0]  mode;

    debug_clk_sequencer_if cmd_if();

    debug_clk_sequencer #(.COUNTER_BITS(32), .PULSE_BITS(32), .RESET_DIVIDER(4)) dut (
        .clk(clk), .reset(reset), .cmd(cmd_if), .abort(abort),
        .div_divider(div_divider), .div_option(div_option), .div_out_enable(div_out_enable),
        .div_write_pulse(div_write_pulse), .div_pulse(div_pulse), .div_reset(div_reset),
        .busy(busy), .done(done), .error(error), .mode(mode)
    );

    always #5 clk = ~clk;

    // divider pulse-mode model: loads on write strobe, one output pulse per cycle until zero
    int unsigned mdl_cnt = 0;
    int          pulses  = 0;
    always @(posedge clk) begin
        if (div_reset)                                       mdl_cnt <= 0;
        else if (div_write_pulse)                            mdl_cnt <= div_pulse;
        else if (div_out_enable && !div_option && mdl_cnt != 0) mdl_cnt <= mdl_cnt - 1;
    end
    always @(negedge clk)
        if (div_out_enable && !div_option && mdl_cnt != 0) pulses <= pulses + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] arg;
        logic [31:0] e_div;
        logic        e_opt, e_oe, e_err;
        logic [1:0]  e_mode;
        int          e_lat, e_rst, e_wp, e_pul;
    } vec_t;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int t = 0;
        while (!cmd_if.cmd_ready && t < 50) begin @(negedge clk); t++; end
        if (!cmd_if.cmd_ready) chk({nm, ".ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_cmd(input string nm, input logic [1:0] op, input logic [31:0] arg,
                           output int lat, output int n_rst, output int n_wp,
                           output int n_busy, output logic [31:0] wp_val);
        lat = 0; n_rst = 0; n_wp = 0; n_busy = 0; wp_val = 0;
        wait_ready(nm);
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = op; cmd_if.cmd_arg = arg;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        pulses = 0;
        do begin
            @(negedge clk);
            lat++;
            if (div_reset) n_rst++;
            if (div_write_pulse) begin n_wp++; wp_val = div_pulse; end
            if (busy) n_busy++;
        end while (!done && lat < 400);
    endtask

    vec_t tbl[14];

    initial begin
        int lat, n_rst, n_wp, n_busy;
        logic [31:0] wp_val;
        string nm;

        tbl[0]  = '{OP_SET,  32'd10,         32'd10,         0, 0, 0, 2'd0, 1, 0, 0, 0};
        tbl[1]  = '{OP_RUN,  32'd0,          32'd10,         1, 1, 0, 2'd1, 1, 0, 0, 0};
        tbl[2]  = '{OP_SET,  32'd6,          32'd6,          1, 1, 0, 2'd1, 2, 1, 0, 0};
        tbl[3]  = '{OP_SET,  32'd1,          32'd6,          1, 1, 1, 2'd1, 1, 0, 0, 0};
        tbl[4]  = '{OP_RUN,  32'd0,          32'd6,          1, 1, 0, 2'd1, 1, 0, 0, 0};
        tbl[5]  = '{OP_SET,  32'd0,          32'd6,          1, 1, 1, 2'd1, 1, 0, 0, 0};
        tbl[6]  = '{OP_STEP, 32'd5,          32'd6,          0, 1, 0, 2'd0, 7, 0, 1, 5};
        tbl[7]  = '{OP_STEP, 32'd0,          32'd6,          0, 1, 0, 2'd0, 1, 0, 0, 0};
        tbl[8]  = '{OP_STOP, 32'd0,          32'd6,          0, 0, 0, 2'd0, 1, 0, 0, 0};
        tbl[9]  = '{OP_STEP, 32'd1,          32'd6,          0, 1, 0, 2'd0, 3, 0, 1, 1};
        tbl[10] = '{OP_SET,  32'd2,          32'd2,          0, 1, 0, 2'd0, 1, 0, 0, 0};
        tbl[11] = '{OP_SET,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 1, 0, 2'd0, 1, 0, 0, 0};
        tbl[12] = '{OP_RUN,  32'd0,          32'hFFFF_FFFF,  1, 1, 0, 2'd1, 1, 0, 0, 0};
        tbl[13] = '{OP_STOP, 32'd0,          32'hFFFF_FFFF,  0, 0, 0, 2'd0, 1, 0, 0, 0};

        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'd0; cmd_if.cmd_arg = 32'd0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst.div_reset", {31'd0, div_reset}, 32'd1);
        chk("rst.divider", div_divider, 32'd4);
        chk("rst.ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        chk("rst.outs", {div_option, div_out_enable, div_write_pulse, done, error, mode}, 32'd0);
        chk("rst.pulse", div_pulse, 32'd0);
        reset = 1'b0;
        #1 chk("rel.div_reset", {31'd0, div_reset}, 32'd1);
        @(negedge clk);
        chk("init.div_reset", {31'd0, div_reset}, 32'd0);
        chk("init.ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        chk("init.busy_done", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            nm = $sformatf("v%0d", i);
            run_cmd(nm, tbl[i].op, tbl[i].arg, lat, n_rst, n_wp, n_busy, wp_val);
            chk({nm, ".lat"}, lat, tbl[i].e_lat);
            chk({nm, ".div_reset_cycles"}, n_rst, tbl[i].e_rst);
            chk({nm, ".write_pulse_cycles"}, n_wp, tbl[i].e_wp);
            if (tbl[i].e_wp != 0) chk({nm, ".div_pulse"}, wp_val, tbl[i].arg);
            chk({nm, ".busy_cycles"}, n_busy, lat);
            chk({nm, ".divider"}, div_divider, tbl[i].e_div);
            chk({nm, ".opt_oe_err"}, {29'd0, div_option, div_out_enable, error},
                {29'd0, tbl[i].e_opt, tbl[i].e_oe, tbl[i].e_err});
            chk({nm, ".mode"}, {30'd0, mode}, {30'd0, tbl[i].e_mode});
            chk({nm, ".pulses"}, pulses, tbl[i].e_pul);
            chk({nm, ".ready_in_done"}, {31'd0, cmd_if.cmd_ready}, 32'd0);
            if (tbl[i].op == OP_STEP) chk({nm, ".mdl_cnt"}, mdl_cnt, 32'd0);
        end

        // STEP 100 aborted after 10 cycles, RUN held on the bus meanwhile
        wait_ready("abort");
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_STEP; cmd_if.cmd_arg = 32'd100;
        @(posedge clk); #1;
        cmd_if.cmd_op = OP_RUN; cmd_if.cmd_arg = 32'd0;
        repeat (10) @(negedge clk);
        chk("abort.held_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        chk("abort.mid_mode", {30'd0, mode}, 32'd2);
        chk("abort.mid_oe", {31'd0, div_out_enable}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort.div_reset", {31'd0, div_reset}, 32'd1);
        chk("abort.done", {31'd0, done}, 32'd1);
        chk("abort.oe_err", {30'd0, div_out_enable, error}, 32'd1);
        chk("abort.mode", {30'd0, mode}, 32'd0);
        @(negedge clk);
        chk("abort.idle_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        chk("abort.div_reset_one", {31'd0, div_reset}, 32'd0);
        chk("abort.mdl_cleared", mdl_cnt, 32'd0);
        @(posedge clk); #1 cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        chk("held_run.done", {31'd0, done}, 32'd1);
        chk("held_run.err_mode", {29'd0, error, mode}, 32'd1);
        chk("held_run.opt_oe", {30'd0, div_option, div_out_enable}, 32'd3);

        // asynchronous reset in the middle of a burst
        wait_ready("mreset");
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_STEP; cmd_if.cmd_arg = 32'd20;
        @(posedge clk); #1 cmd_if.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mreset.pre_mode", {30'd0, mode}, 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("mreset.div_reset", {31'd0, div_reset}, 32'd1);
        chk("mreset.divider", div_divider, 32'd4);
        chk("mreset.ready_busy", {30'd0, cmd_if.cmd_ready, busy}, 32'd1);
        chk("mreset.outs", {div_option, div_out_enable, div_write_pulse, done, error, mode}, 32'd0);
        chk("mreset.pulse", div_pulse, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mreset.init_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        run_cmd("step3", OP_STEP, 32'd3, lat, n_rst, n_wp, n_busy, wp_val);
        chk("step3.lat", lat, 32'd5);
        chk("step3.wp", n_wp, 32'd1);
        chk("step3.div_pulse", wp_val, 32'd3);
        chk("step3.pulses", pulses, 32'd3);
        chk("step3.mode_oe", {29'd0, mode, div_out_enable}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule
